// File: rtl/aoi_share_pkg.sv
// Shared types and helpers for the AOI21 share arbiter and its round-robin picker.
package aoi_share_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, cyclically over N.
module rr_pick
  import aoi_share_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int unsigned    j;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i is always < N, so one subtraction is enough to wrap.
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      cand = IDW'(j);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/aoi21_share_arbiter.sv
// N requesters share one registered AOI21 stage; round-robin accept, tagged valid/ready result.
module aoi21_share_arbiter
  import aoi_share_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  input  logic [N*W-1:0] c_flat,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_y,
  output logic [IDW-1:0] out_id,
  output logic [15:0]    op_count
);

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [N-1:0]   pick_gnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           slot_open;
  logic           accept;
  logic [W-1:0]   a_sel, b_sel, c_sel;

  rr_pick #(.N(N)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // rst_n gates the slot so no grant is ever shown while reset is held.
  assign slot_open = rst_n && ((state_q == EMPTY) || out_ready);
  assign accept    = slot_open && pick_any;
  assign gnt       = slot_open ? pick_gnt : '0;

  assign a_sel = a_flat[pick_idx*W +: W];
  assign b_sel = b_flat[pick_idx*W +: W];
  assign c_sel = c_flat[pick_idx*W +: W];

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      y_d     = ~((a_sel & b_sel) | c_sel);
      id_d    = pick_idx;
      ptr_d   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_y     = y_q;
  assign out_id    = id_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_aoi21_share_arbiter.sv
// Scoreboard bench for aoi21_share_arbiter: driver predicts grants and results, monitor checks outputs.
module tb_aoi21_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  a_flat = '0, b_flat = '0, c_flat = '0;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_y;
  logic [1:0]      out_id;
  logic [15:0]     op_count;

  aoi21_share_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .c_flat    (c_flat),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] y;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mptr = 0;
  int   mcnt = 0;
  bit   mvalid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, modulo N.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock of stimulus; returns the index the model expects to be accepted (or -1).
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic [N*W-1:0] c, input logic rdy, output int g);
    logic [3:0] av, bv, cv;
    @(posedge clk);
    #1;
    req = r; a_flat = a; b_flat = b; c_flat = c; out_ready = rdy;
    @(negedge clk);
    g = (!mvalid || rdy) ? model_pick(r, mptr) : -1;
    check("gnt", gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
    check("out_valid", out_valid, mvalid);
    check("op_count", op_count, mcnt);
    if (g >= 0) begin
      av = a[g*W +: W]; bv = b[g*W +: W]; cv = c[g*W +: W];
      q.push_back('{id: g, y: ~((av & bv) | cv)});
      mptr   = (g + 1) % N;
      mcnt   = (mcnt < 65535) ? mcnt + 1 : mcnt;
      mvalid = 1'b1;
    end else if (mvalid && rdy) begin
      mvalid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got id %0d y %0h, expected no result", out_id, out_y);
      end else begin
        check("out_id", out_id, q[0].id);
        check("out_y", out_y, q[0].y);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [N-1:0]   cr;
    logic [N*W-1:0] ca, cb, cc;

    // Reset held with all requests high.
    req = '1; out_ready = 1'b1;
    #23;
    check("rst_gnt", gnt, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_id", out_id, 0);
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // First grant after reset goes to requester 0.
    step(4'b1111, '0, '0, '0, 1'b1, g);
    // Single op on requester 2: expect y = 4'b0110.
    step(4'b0100, 16'h0C00, 16'h0A00, 16'h0100, 1'b1, g);
    // Fairness sweep.
    for (int i = 0; i < 5; i++)
      step(4'b1111, 16'h1234, 16'hABCD, 16'h0F0F, 1'b1, g);
    // Backpressure: slot closed, result held.
    for (int i = 0; i < 5; i++)
      step(4'b1111, 16'h5A5A, 16'hC3C3, 16'h0000, 1'b0, g);
    step(4'b1111, 16'h5A5A, 16'hC3C3, 16'h0000, 1'b1, g);
    // Corner operand values on requester 1.
    step(4'b0010, 16'h00F0, 16'h00F0, 16'h00F0, 1'b1, g);
    step(4'b0010, 16'h0000, 16'h0000, 16'h0000, 1'b1, g);
    step(4'b0010, 16'h00F0, 16'h0000, 16'h0000, 1'b1, g);
    step(4'b0000, '0, '0, '0, 1'b1, g);
    step(4'b0000, '0, '0, '0, 1'b1, g);

    // Async reset while a result is pending.
    step(4'b0001, 16'h000F, 16'h0003, 16'h0000, 1'b1, g);
    @(posedge clk);
    #2;
    check("pre_reset_valid", out_valid, 1);
    req = '0;
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_gnt", gnt, 0);
    q.delete();
    mptr = 0; mcnt = 0; mvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(4'b1000, 16'h9000, 16'hF000, 16'h2000, 1'b1, g);
    step(4'b0000, '0, '0, '0, 1'b1, g);

    // Randomised traffic; pending requesters keep their request and operands.
    cr = '0; ca = '0; cb = '0; cc = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(cr[i] && i != g && ($urandom % 8) != 0)) begin
          cr[i] = 1'($urandom % 2);
          ca[i*W +: W] = 4'($urandom);
          cb[i*W +: W] = 4'($urandom);
          cc[i*W +: W] = 4'($urandom);
        end
      end
      step(cr, ca, cb, cc, 1'(($urandom % 4) != 0), g);
    end

    // Drain.
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, 1'b1, g);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
